// File: rtl/decode_pkg.sv
// Shared types for the RV32 decode stage: ALU op encoding, opcodes, immediate
// formats, operand selects and the registered control bundle.
package decode_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;
    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
    typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    rf_we;
        logic    mem_we;
        logic    mem_re;
        logic    branch;
        logic    jump;
        logic    illegal;
    } decode_ctrl_t;

endpackage

// File: rtl/decode_stage_pipe_imm_gen.sv
// Combinational RV32 immediate generator: classifies the instruction format
// from the opcode and produces the sign-extended immediate.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output imm_fmt_e        fmt_o,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        fmt_o = FMT_R;
        case (instr_i[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt_o = FMT_I;
            OPC_STORE:                      fmt_o = FMT_S;
            OPC_BRANCH:                     fmt_o = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt_o = FMT_U;
            OPC_JAL:                        fmt_o = FMT_J;
            default:                        fmt_o = FMT_R;
        endcase

        imm32 = '0;
        case (fmt_o)
            FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32 decode stage with valid/ready handshake and one output register.
// Define DECODE_RV32M_EN to decode the M extension (MUL/DIV/REM family).
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = ($clog2(NUM_REGS) < 5) ? 5 : $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output alu_op_e           out_alu_op,
    output logic [XLEN-1:0]   out_operand1,
    output logic [XLEN-1:0]   out_operand2,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic [2:0]        out_funct3,
    output logic              out_rf_we,
    output logic              out_mem_we,
    output logic              out_mem_re,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_illegal
);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign f7     = in_instr[31:25];

    assign rs1_addr = REG_AW'(rs1);
    assign rs2_addr = REG_AW'(rs2);

    imm_fmt_e          fmt;
    logic [XLEN-1:0]   imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr),
        .fmt_o   (fmt),
        .imm_o   (imm)
    );

    decode_ctrl_t      ctrl_d, ctrl_q;
    op1_sel_e          op1_sel;
    op2_sel_e          op2_sel;
    logic              use_rd, use_rs1, use_rs2, bad_enc, bad_reg;
    logic [XLEN-1:0]   op1_d, op2_d, op1_q, op2_q, imm_q, pc_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic [2:0]        f3_q;
    logic              valid_q, accept;

    always_comb begin
        ctrl_d  = '0;
        op1_sel = OP1_RS1;
        op2_sel = OP2_IMM;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad_enc = 1'b0;
        case (opcode)
            OPC_LUI:   begin op1_sel = OP1_ZERO; ctrl_d.rf_we = 1'b1; use_rd = 1'b1; end
            OPC_AUIPC: begin op1_sel = OP1_PC;   ctrl_d.rf_we = 1'b1; use_rd = 1'b1; end
            OPC_JAL: begin
                op1_sel = OP1_PC; op2_sel = OP2_FOUR;
                ctrl_d.jump = 1'b1; ctrl_d.rf_we = 1'b1; use_rd = 1'b1;
            end
            OPC_JALR: begin
                op1_sel = OP1_PC; op2_sel = OP2_FOUR;
                ctrl_d.jump = 1'b1; ctrl_d.rf_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                bad_enc = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                op2_sel = OP2_RS2; ctrl_d.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3[2:1])
                    2'b00:   ctrl_d.alu_op = ALU_SUB;
                    2'b10:   ctrl_d.alu_op = ALU_SLT;
                    2'b11:   ctrl_d.alu_op = ALU_SLTU;
                    default: bad_enc = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl_d.mem_re = 1'b1; ctrl_d.rf_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                bad_enc = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                ctrl_d.mem_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                bad_enc = f3[2] || (f3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                ctrl_d.rf_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                case (f3)
                    3'b000: ctrl_d.alu_op = ALU_ADD;
                    3'b001: begin ctrl_d.alu_op = ALU_SLL; bad_enc = (f7 != 7'b0000000); end
                    3'b010: ctrl_d.alu_op = ALU_SLT;
                    3'b011: ctrl_d.alu_op = ALU_SLTU;
                    3'b100: ctrl_d.alu_op = ALU_XOR;
                    3'b101: begin
                        ctrl_d.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                        bad_enc = ({f7[6], f7[4:0]} != 6'b0);
                    end
                    3'b110: ctrl_d.alu_op = ALU_OR;
                    default: ctrl_d.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                op2_sel = OP2_RS2; ctrl_d.rf_we = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: ctrl_d.alu_op = ALU_ADD;
                        3'b001: ctrl_d.alu_op = ALU_SLL;
                        3'b010: ctrl_d.alu_op = ALU_SLT;
                        3'b011: ctrl_d.alu_op = ALU_SLTU;
                        3'b100: ctrl_d.alu_op = ALU_XOR;
                        3'b101: ctrl_d.alu_op = ALU_SRL;
                        3'b110: ctrl_d.alu_op = ALU_OR;
                        default: ctrl_d.alu_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    ctrl_d.alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    ctrl_d.alu_op = ALU_SRA;
`ifdef DECODE_RV32M_EN
                end else if (f7 == 7'b0000001) begin
                    // M ops are enumerated in funct3 order starting at ALU_MUL
                    ctrl_d.alu_op = alu_op_e'(ALU_OP_W'(ALU_MUL) + ALU_OP_W'(f3));
`endif
                end else begin
                    bad_enc = 1'b1;
                end
            end
            default: bad_enc = 1'b1;
        endcase

        bad_reg = (use_rd  && (int'(rd)  >= NUM_REGS)) ||
                  (use_rs1 && (int'(rs1) >= NUM_REGS)) ||
                  (use_rs2 && (int'(rs2) >= NUM_REGS));
        ctrl_d.illegal = bad_enc || bad_reg;
        if (ctrl_d.illegal) begin
            ctrl_d.rf_we  = 1'b0;
            ctrl_d.mem_we = 1'b0;
            ctrl_d.mem_re = 1'b0;
            ctrl_d.branch = 1'b0;
            ctrl_d.jump   = 1'b0;
        end
        if (rd == 5'd0) ctrl_d.rf_we = 1'b0;

        case (op1_sel)
            OP1_PC:   op1_d = in_pc;
            OP1_ZERO: op1_d = '0;
            default:  op1_d = rs1_data;
        endcase
        case (op2_sel)
            OP2_RS2:  op2_d = rs2_data;
            OP2_FOUR: op2_d = XLEN'(4);
            default:  op2_d = imm;
        endcase
        rd_d = (fmt == FMT_S || fmt == FMT_B) ? '0 : REG_AW'(rd);
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm;
            pc_q    <= in_pc;
            rd_q    <= rd_d;
            f3_q    <= f3;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign out_alu_op   = ctrl_q.alu_op;
    assign out_operand1 = op1_q;
    assign out_operand2 = op2_q;
    assign out_imm      = imm_q;
    assign out_pc       = pc_q;
    assign out_rd       = rd_q;
    assign out_funct3   = f3_q;
    assign out_rf_we    = ctrl_q.rf_we;
    assign out_mem_we   = ctrl_q.mem_we;
    assign out_mem_re   = ctrl_q.mem_re;
    assign out_branch   = ctrl_q.branch;
    assign out_jump     = ctrl_q.jump;
    assign out_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: vector table plus scoreboard,
// stall/flush sequences, and an RV32E instance for register-range and reset checks.
module tb_decode_stage_pipe;
    import decode_pkg::*;

    localparam logic [31:0] PC   = 32'h0000_0100;
    localparam logic [31:0] RS1D = 32'd10;
    localparam logic [31:0] RS2D = 32'h0000_0020;

    typedef struct {
        logic [31:0] instr;
        alu_op_e     alu;
        logic [31:0] op1, op2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rf_we, mem_we, mem_re, br, jmp, ill, chk_ops;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, rst_e = 1'b1;
    logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, out_ready_e = 1'b1;
    logic [31:0] in_instr = 32'h0000_0013, in_pc = PC, rs1_data = RS1D, rs2_data = RS2D;

    logic        in_ready, out_valid, out_rf_we, out_mem_we, out_mem_re, out_branch, out_jump, out_illegal;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    alu_op_e     out_alu_op;
    logic [31:0] out_operand1, out_operand2, out_imm, out_pc;
    logic [2:0]  out_funct3;

    logic        in_ready_e, out_valid_e, out_rf_we_e, out_mem_we_e, out_mem_re_e, out_branch_e, out_jump_e, out_illegal_e;
    logic [4:0]  rs1_addr_e, rs2_addr_e, out_rd_e;
    alu_op_e     out_alu_op_e;
    logic [31:0] out_operand1_e, out_operand2_e, out_imm_e, out_pc_e;
    logic [2:0]  out_funct3_e;

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_operand1(out_operand1), .out_operand2(out_operand2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rf_we(out_rf_we), .out_mem_we(out_mem_we), .out_mem_re(out_mem_re),
        .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    decode_stage_pipe #(.XLEN(32), .NUM_REGS(16)) dut_e (
        .clk(clk), .rst(rst_e), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_e),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr_e), .rs2_addr(rs2_addr_e),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid_e), .out_ready(out_ready_e),
        .out_alu_op(out_alu_op_e), .out_operand1(out_operand1_e), .out_operand2(out_operand2_e),
        .out_imm(out_imm_e), .out_pc(out_pc_e), .out_rd(out_rd_e), .out_funct3(out_funct3_e),
        .out_rf_we(out_rf_we_e), .out_mem_we(out_mem_we_e), .out_mem_re(out_mem_re_e),
        .out_branch(out_branch_e), .out_jump(out_jump_e), .out_illegal(out_illegal_e)
    );

    int unsigned n_vec = 0, n_err = 0;
    string       tag = "reset";
    vec_t        sb[$];
    logic        exp_valid = 1'b0;
    vec_t        tbl[18];
    vec_t        v_idle, v_add, v_sub, v_x17;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h want %h", tag, nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %b want %b", tag, nm, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        chk_b("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL %s scoreboard: got empty want entry", tag);
            end else begin
                e = sb[0];
                if (e.chk_ops) begin
                    chk("alu_op", 32'(out_alu_op), 32'(e.alu));
                    chk("operand1", out_operand1, e.op1);
                    chk("operand2", out_operand2, e.op2);
                    chk("imm", out_imm, e.imm);
                    chk("rd", 32'(out_rd), 32'(e.rd));
                    chk("pc", out_pc, PC);
                end
                chk("funct3", 32'(out_funct3), 32'(e.f3));
                chk_b("rf_we", out_rf_we, e.rf_we);
                chk_b("mem_we", out_mem_we, e.mem_we);
                chk_b("mem_re", out_mem_re, e.mem_re);
                chk_b("branch", out_branch, e.br);
                chk_b("jump", out_jump, e.jmp);
                chk_b("illegal", out_illegal, e.ill);
            end
        end
    endtask

    // One handshake cycle: drive at negedge, update the model, check after posedge.
    task automatic cycle(input vec_t v, input logic vld, input logic ordy, input logic fl);
        logic acc;
        @(negedge clk);
        in_valid = vld; in_instr = v.instr; out_ready = ordy; flush = fl;
        #1;
        chk_b("in_ready", in_ready, !exp_valid || ordy);
        if (vld) begin
            chk("rs1_addr", 32'(rs1_addr), 32'(v.instr[19:15]));
            chk("rs2_addr", 32'(rs2_addr), 32'(v.instr[24:20]));
        end
        acc = vld && (!exp_valid || ordy) && !fl;
        if (exp_valid && (ordy || fl)) void'(sb.pop_front());
        if (acc) sb.push_back(v);
        exp_valid = !fl && (acc || (exp_valid && !ordy));
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        tbl[0]  = '{32'hFFD08293, ALU_ADD,  RS1D, 32'hFFFFFFFD, 32'hFFFFFFFD, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{32'h0021A423, ALU_ADD,  RS1D, 32'd8,        32'd8,        5'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{32'h003100B3, ALU_ADD,  RS1D, RS2D,         32'd0,        5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{32'h403100B3, ALU_SUB,  RS1D, RS2D,         32'd0,        5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{32'h123453B7, ALU_ADD,  32'd0, 32'h12345000, 32'h12345000, 5'd7, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{32'h80000397, ALU_ADD,  PC,   32'h80000000, 32'h80000000, 5'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{32'h008000EF, ALU_ADD,  PC,   32'd4,        32'd8,        5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{32'h00008067, ALU_ADD,  PC,   32'd4,        32'd0,        5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{32'h00208863, ALU_SUB,  RS1D, RS2D,         32'd16,       5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{32'hFE20EEE3, ALU_SLTU, RS1D, RS2D,         32'hFFFFFFFC, 5'd0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{32'hFF80A203, ALU_ADD,  RS1D, 32'hFFFFFFF8, 32'hFFFFFFF8, 5'd4, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{32'h4030D293, ALU_SRA,  RS1D, 32'h403,      32'h403,      5'd5, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{32'hFFFFFFFF, ALU_ADD,  32'd0, 32'd0, 32'd0, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{32'h40309293, ALU_ADD,  32'd0, 32'd0, 32'd0, 5'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{32'h0020A863, ALU_ADD,  32'd0, 32'd0, 32'd0, 5'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef DECODE_RV32M_EN
        tbl[15] = '{32'h023100B3, ALU_MUL,  RS1D, RS2D,         32'd0,        5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        tbl[15] = '{32'h023100B3, ALU_ADD,  32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        tbl[16] = '{32'h00208033, ALU_ADD,  RS1D, RS2D,         32'd0,        5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{32'h0020C863, ALU_SLT,  RS1D, RS2D,         32'd16,       5'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        v_idle = '{32'h00000013, ALU_ADD, RS1D, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        v_add  = tbl[2];
        v_sub  = tbl[3];
        v_x17  = '{32'h002088B3, ALU_ADD, RS1D, RS2D, 32'd0, 5'd17, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        #2;
        chk_b("out_valid", out_valid, 1'b0);
        chk_b("in_ready", in_ready, 1'b1);
        chk("alu_op", 32'(out_alu_op), 32'(ALU_ADD));
        chk("operand1", out_operand1, 32'd0);
        chk("imm", out_imm, 32'd0);
        chk_b("rf_we", out_rf_we, 1'b0);
        chk_b("illegal", out_illegal, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst_e = 1'b0;

        for (int i = 0; i < 18; i++) begin
            tag = $sformatf("vec%0d", i);
            cycle(tbl[i], 1'b1, 1'b1, 1'b0);
        end
        tag = "drain";
        cycle(v_idle, 1'b0, 1'b1, 1'b0);

        // Stall: bundle must hold for three cycles, then the next one enters immediately
        tag = "stall";
        cycle(tbl[0], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(v_add, 1'b1, 1'b0, 1'b0);
        tag = "release";
        cycle(v_add, 1'b1, 1'b1, 1'b0);

        // Flush kills both the held bundle and the incoming instruction
        tag = "flush_rdy";
        cycle(v_sub, 1'b1, 1'b1, 1'b1);
        cycle(v_idle, 1'b0, 1'b1, 1'b0);
        tag = "flush_hold";
        cycle(v_add, 1'b1, 1'b0, 1'b0);
        cycle(v_sub, 1'b1, 1'b0, 1'b1);
        cycle(v_idle, 1'b0, 1'b0, 1'b0);

        // RV32E instance: x17 is out of range
        tag = "rv32e_x17";
        cycle(v_x17, 1'b1, 1'b1, 1'b0);
        chk_b("e_valid", out_valid_e, 1'b1);
        chk_b("e_illegal", out_illegal_e, 1'b1);
        chk_b("e_rf_we", out_rf_we_e, 1'b0);
        tag = "rv32e_add";
        cycle(v_add, 1'b1, 1'b1, 1'b0);
        chk_b("e_illegal", out_illegal_e, 1'b0);
        chk_b("e_rf_we", out_rf_we_e, 1'b1);
        chk("e_rd", 32'(out_rd_e), 32'd1);

        // Async reset while the RV32E stage is stalled
        tag = "rv32e_rst";
        out_ready_e = 1'b0;
        cycle(v_idle, 1'b0, 1'b1, 1'b0);
        chk_b("e_valid_held", out_valid_e, 1'b1);
        chk("e_rd_held", 32'(out_rd_e), 32'd1);
        chk_b("e_in_ready", in_ready_e, 1'b0);
        #1 rst_e = 1'b1;
        #1;
        chk_b("e_valid_rst", out_valid_e, 1'b0);
        chk_b("e_in_ready_rst", in_ready_e, 1'b1);
        #1 rst_e = 1'b0;
        out_ready_e = 1'b1;
        tag = "end";
        cycle(v_idle, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
